// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the mm:ss countdown timer: FSM state encoding,
// BCD digit limits and the load-value clamp.
package countdown_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Saturates a {tens, ones} BCD pair: ones to 9, tens to tens_max.
    function automatic logic [7:0] clamp_pair(input logic [7:0] raw, input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (raw[7:4] > tens_max) ? tens_max : raw[7:4];
        ones = (raw[3:0] > BCD_NINE) ? BCD_NINE : raw[3:0];
        return {tens, ones};
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Key/switch inputs and display/status outputs of the countdown timer core.
// The master side drives keys and switches; the slave side is the timer.
interface countdown_timer_ctrl_if #(
    parameter int LED_W = 10
);
    logic             key_load_n;
    logic             key_run_n;
    logic             sel_min;
    logic [7:0]       sw;
    logic [3:0]       min_tens;
    logic [3:0]       min_ones;
    logic [3:0]       sec_tens;
    logic [3:0]       sec_ones;
    logic             running;
    logic             alarm;
    logic [LED_W-1:0] led;

    modport master (
        output key_load_n, key_run_n, sel_min, sw,
        input  min_tens, min_ones, sec_tens, sec_ones, running, alarm, led
    );

    modport slave (
        input  key_load_n, key_run_n, sel_min, sw,
        output min_tens, min_ones, sec_tens, sec_ones, running, alarm, led
    );
endinterface

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// Countdown tick divider: counts 0..TICK_DIV-1 while enabled and pulses tick on the
// last count. clr restarts the period; while disabled the count is held.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: tick is gated by en so a count frozen at LAST during a pause cannot fire.
    assign tick = en && (r_cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown timer core: key sync, BCD time register, run/pause/alarm FSM.
// Define COUNTDOWN_BLINK_EN to make the LED bank blink while in ALARM.
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int MIN_TENS_MAX = 9,
    parameter int ALARM_TICKS  = 10,
    parameter int LED_W        = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_timer_ctrl_if.slave bus
);
    localparam logic [3:0]    MIN_TENS_LIM = 4'(MIN_TENS_MAX);
    localparam int            AW           = (ALARM_TICKS > 2) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [AW-1:0] ALARM_LAST   = AW'((ALARM_TICKS > 0) ? ALARM_TICKS - 1 : 0);

    state_t           r_state;
    bcd_time_t        r_time;
    logic             r_running;
    logic             r_alarm;
    logic [LED_W-1:0] r_led;
    logic             r_blink;
    logic [AW-1:0]    r_alarm_cnt;

    logic [2:0]       r_load_sync;
    logic [2:0]       r_run_sync;
    logic             r_load_press;
    logic             r_run_press;

    bcd_time_t        w_dec;
    logic             w_time_zero;
    logic             w_dec_zero;
    logic             w_load_press;
    logic             w_tick;
    logic             w_presc_en;
    logic             w_presc_clr;
    logic [7:0]       w_load_min;
    logic [7:0]       w_load_sec;

    function automatic logic [LED_W-1:0] run_led(input logic b);
        run_led    = '0;
        run_led[0] = b;
    endfunction

    // Two sync stages plus one history stage; the registered fall detect lands
    // the press pulse three cycles after the pin goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_sync  <= 3'b111;
            r_run_sync   <= 3'b111;
            r_load_press <= 1'b0;
            r_run_press  <= 1'b0;
        end else begin
            r_load_sync  <= {r_load_sync[1:0], bus.key_load_n};
            r_run_sync   <= {r_run_sync[1:0], bus.key_run_n};
            r_load_press <= r_load_sync[2] & ~r_load_sync[1];
            r_run_press  <= r_run_sync[2] & ~r_run_sync[1];
        end
    end

    // Run wins over a simultaneous load.
    assign w_load_press = r_load_press & ~r_run_press;

    assign w_load_min = clamp_pair(bus.sw, MIN_TENS_LIM);
    assign w_load_sec = clamp_pair(bus.sw, SEC_TENS_MAX);

    assign w_time_zero = (r_time == '0);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_dec          = r_time;
        w_dec.sec_ones = r_time.sec_ones - 4'd1;
        if (r_time.sec_ones == 4'd0) begin
            w_dec.sec_ones = BCD_NINE;
            w_dec.sec_tens = r_time.sec_tens - 4'd1;
            if (r_time.sec_tens == 4'd0) begin
                w_dec.sec_tens = SEC_TENS_MAX;
                w_dec.min_ones = r_time.min_ones - 4'd1;
                if (r_time.min_ones == 4'd0) begin
                    w_dec.min_ones = BCD_NINE;
                    w_dec.min_tens = r_time.min_tens - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero  = (w_dec == '0);
    assign w_presc_en  = (r_state == ST_RUN) || (r_state == ST_ALARM);
    assign w_presc_clr = (r_state == ST_IDLE) && r_run_press && !w_time_zero;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_presc_en),
        .clr   (w_presc_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_time      <= '0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
            r_led       <= '0;
            r_blink     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_run_press) begin
                        if (!w_time_zero) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_blink   <= 1'b0;
                            r_led     <= '0;
                        end
                    end else if (w_load_press) begin
                        if (bus.sel_min) begin
                            r_time.min_tens <= w_load_min[7:4];
                            r_time.min_ones <= w_load_min[3:0];
                        end else begin
                            r_time.sec_tens <= w_load_sec[7:4];
                            r_time.sec_ones <= w_load_sec[3:0];
                        end
                    end
                end
                ST_RUN: begin
                    if (r_run_press) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                        r_led     <= run_led(1'b1);
                    end else if (w_tick) begin
                        r_time <= w_dec;
                        if (w_dec_zero) begin
                            r_state     <= ST_ALARM;
                            r_running   <= 1'b0;
                            r_alarm     <= 1'b1;
                            r_blink     <= 1'b1;
                            r_alarm_cnt <= '0;
                            r_led       <= '1;
                        end else begin
                            r_blink <= ~r_blink;
                            r_led   <= run_led(~r_blink);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (r_run_press) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_led     <= run_led(r_blink);
                    end else if (w_load_press) begin
                        r_state <= ST_IDLE;
                        r_led   <= '0;
                    end
                end
                ST_ALARM: begin
                    if (r_run_press || r_load_press) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                        r_led   <= '0;
                    end else if (w_tick) begin
                        if ((ALARM_TICKS != 0) && (r_alarm_cnt == ALARM_LAST)) begin
                            r_state <= ST_IDLE;
                            r_alarm <= 1'b0;
                            r_led   <= '0;
                        end else begin
                            r_alarm_cnt <= r_alarm_cnt + 1'b1;
                            r_blink     <= ~r_blink;
`ifdef COUNTDOWN_BLINK_EN
                            r_led       <= {LED_W{~r_blink}};
`else
                            r_led       <= '1;
`endif
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.min_tens = r_time.min_tens;
    assign bus.min_ones = r_time.min_ones;
    assign bus.sec_tens = r_time.sec_tens;
    assign bus.sec_ones = r_time.sec_ones;
    assign bus.running  = r_running;
    assign bus.alarm    = r_alarm;
    assign bus.led      = r_led;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed steps plus random key/switch activity,
// compared every cycle against a seconds-based reference model.
module tb_countdown_timer_ctrl;
    localparam int TICK_DIV     = 4;
    localparam int MIN_TENS_MAX = 9;
    localparam int ALARM_TICKS  = 3;
    localparam int LED_W        = 10;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    countdown_timer_ctrl_if #(.LED_W(LED_W)) bus ();

    countdown_timer_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .MIN_TENS_MAX (MIN_TENS_MAX),
        .ALARM_TICKS  (ALARM_TICKS),
        .LED_W        (LED_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time kept as whole minutes and seconds.
    int       m_state;
    int       m_min;
    int       m_sec;
    int       m_pc;
    int       m_run_ticks;
    int       m_alarm_ticks;
    bit [3:0] m_hl;
    bit [3:0] m_hr;

    function automatic void model_reset();
        m_state       = M_IDLE;
        m_min         = 0;
        m_sec         = 0;
        m_pc          = 0;
        m_run_ticks   = 0;
        m_alarm_ticks = 0;
        m_hl          = 4'hF;
        m_hr          = 4'hF;
    endfunction

    function automatic void model_load(input bit sel, input logic [7:0] v);
        int tens;
        int ones;
        int lim;
        lim  = sel ? MIN_TENS_MAX : 5;
        tens = (int'(v[7:4]) > lim) ? lim : int'(v[7:4]);
        ones = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        if (sel) m_min = tens * 10 + ones;
        else     m_sec = tens * 10 + ones;
    endfunction

    // A press acts on the 4th clock edge after the pin is first seen low.
    function automatic void model_edge();
        bit lp;
        bit rp;
        bit tick;
        int total;
        lp   = m_hl[3] & ~m_hl[2];
        rp   = m_hr[3] & ~m_hr[2];
        m_hl = {m_hl[2:0], bus.key_load_n};
        m_hr = {m_hr[2:0], bus.key_run_n};
        if (rp) lp = 1'b0;
        tick = (m_state == M_RUN || m_state == M_ALARM) && (m_pc == TICK_DIV - 1);
        if (m_state == M_RUN || m_state == M_ALARM) m_pc = (m_pc + 1) % TICK_DIV;
        total = m_min * 60 + m_sec;
        case (m_state)
            M_IDLE: begin
                if (rp) begin
                    if (total != 0) begin
                        m_state     = M_RUN;
                        m_pc        = 0;
                        m_run_ticks = 0;
                    end
                end else if (lp) begin
                    model_load(bus.sel_min, bus.sw);
                end
            end
            M_RUN: begin
                if (rp) begin
                    m_state = M_PAUSE;
                end else if (tick) begin
                    total = total - 1;
                    m_min = total / 60;
                    m_sec = total % 60;
                    if (total == 0) begin
                        m_state       = M_ALARM;
                        m_alarm_ticks = 0;
                    end else begin
                        m_run_ticks++;
                    end
                end
            end
            M_PAUSE: begin
                if (rp)      m_state = M_RUN;
                else if (lp) m_state = M_IDLE;
            end
            default: begin
                if (rp || lp) begin
                    m_state = M_IDLE;
                end else if (tick) begin
                    m_alarm_ticks++;
                    if (ALARM_TICKS != 0 && m_alarm_ticks == ALARM_TICKS) m_state = M_IDLE;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] model_vec();
        logic [LED_W-1:0] l;
        logic [15:0]      digits;
        l = '0;
        case (m_state)
            M_RUN:   l[0] = (m_run_ticks % 2) == 1;
            M_PAUSE: l[0] = 1'b1;
            M_ALARM: begin
`ifdef COUNTDOWN_BLINK_EN
                l = ((m_alarm_ticks % 2) == 0) ? '1 : '0;
`else
                l = '1;
`endif
            end
            default: l = '0;
        endcase
        digits = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
        return 32'({digits, m_state == M_RUN, m_state == M_ALARM, l});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                    bus.running, bus.alarm, bus.led});
    endfunction

    function automatic logic [31:0] dut_time();
        return 32'({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!reset) model_reset();
            else        model_edge();
            #1;
            check("cycle", dut_vec(), model_vec());
        end
    endtask

    task automatic press(input bit use_run, input bit use_load);
        if (use_run)  bus.key_run_n  = 1'b0;
        if (use_load) bus.key_load_n = 1'b0;
        step(2);
        bus.key_run_n  = 1'b1;
        bus.key_load_n = 1'b1;
        step(2);
    endtask

    task automatic load(input bit sel, input logic [7:0] v);
        bus.sel_min = sel;
        bus.sw      = v;
        press(1'b0, 1'b1);
    endtask

    initial begin
        bus.key_load_n = 1'b1;
        bus.key_run_n  = 1'b1;
        bus.sel_min    = 1'b0;
        bus.sw         = 8'hFF;
        reset          = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        #1 check("reset_state", dut_vec(), 32'h0);
        step(2);
        reset = 1'b1;
        step(2);

        // Load clamping.
        load(1'b0, 8'hFF);
        check("load_sec_clamp", dut_time(), 32'h0059);
        load(1'b1, 8'hA7);
        check("load_min_clamp", dut_time(), 32'h9759);

        // Short count into ALARM, then auto-return.
        load(1'b1, 8'h00);
        load(1'b0, 8'h02);
        press(1'b1, 1'b0);
        check("run_start", 32'(bus.running), 32'h1);
        step(4);
        check("first_dec", dut_time(), 32'h0001);
        step(4);
        check("reach_zero", dut_time(), 32'h0000);
        check("alarm_on", 32'({bus.alarm, bus.running}), 32'h2);
        check("alarm_led", 32'(bus.led), 32'h3FF);
        step(4);
`ifdef COUNTDOWN_BLINK_EN
        check("alarm_blink", 32'(bus.led), 32'h000);
`else
        check("alarm_steady", 32'(bus.led), 32'h3FF);
`endif
        step(8);
        check("alarm_timeout", 32'({bus.alarm, bus.led}), 32'h0);

        // Borrow chains.
        load(1'b1, 8'h01);
        load(1'b0, 8'h00);
        press(1'b1, 1'b0);
        step(4);
        check("borrow_min", dut_time(), 32'h0059);
        step(1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("pause_to_idle", 32'({bus.running, bus.led}), 32'h0);
        load(1'b1, 8'h10);
        load(1'b0, 8'h00);
        press(1'b1, 1'b0);
        step(4);
        check("borrow_tens", dut_time(), 32'h0959);
        step(1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // Pause two cycles into the period, hold, resume.
        load(1'b1, 8'h00);
        load(1'b0, 8'h30);
        bus.key_run_n = 1'b0; step(1);
        bus.key_run_n = 1'b1; step(1);
        bus.key_run_n = 1'b0; step(1);
        bus.key_run_n = 1'b1; step(3);
        check("paused", 32'({bus.running, bus.led}), 32'h001);
        step(20);
        check("pause_frozen", dut_time(), 32'h0030);
        press(1'b1, 1'b0);
        check("resume", 32'(bus.running), 32'h1);
        step(1);
        check("resume_hold", dut_time(), 32'h0030);
        step(1);
        check("resume_dec", dut_time(), 32'h0029);

        // Run at 00:00 ignored; simultaneous load+run lets run win.
        step(1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        load(1'b1, 8'h00);
        load(1'b0, 8'h00);
        press(1'b1, 1'b0);
        check("run_at_zero", 32'(bus.running), 32'h0);
        load(1'b0, 8'h05);
        bus.sw = 8'h33;
        press(1'b1, 1'b1);
        check("run_wins", 32'({bus.running, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}),
              32'h10005);

        // Reset mid-count.
        step(5);
        reset = 1'b0;
        #1 check("reset_abort", dut_vec(), 32'h0);
        model_reset();
        step(2);
        reset = 1'b1;
        step(2);

        // Random key and switch activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) bus.key_run_n  = ~bus.key_run_n;
            if ($urandom_range(0, 5) == 0) bus.key_load_n = ~bus.key_load_n;
            if ($urandom_range(0, 3) == 0) begin
                bus.sel_min = ($urandom_range(0, 3) == 0);
                bus.sw[7:4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                bus.sw[3:0] = 4'($urandom_range(0, 15));
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
